rgb2raw_mosaic: RTL and testbench

- Re-mosaics an RGB pixel stream into a 12-bit Bayer RAW stream, one RAW component per clock.
- Sits upstream of the demosaic/capture path as a sensor emulator for loopback and bench injection.
- Each input RGB pixel becomes one 2x2 Bayer quad:
  - upper row: G1 at even x, R at odd x
  - lower row: B at even x, G2 at odd x
  - G1 = G2 = input green.

---
 rtl/rgb2raw_mosaic.sv | 169 ++++++++++++++++
 tb/tb_rgb2raw_mosaic.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2raw_mosaic.sv
// rgb2raw_mosaic: re-mosaics an RGB pixel stream into a 12-bit Bayer RAW stream.
//
// Each accepted RGB pixel k of a line becomes one 2x2 Bayer quad:
//   upper row (Y = 2*pair)   : G1 at X = 2k, R  at X = 2k+1
//   lower row (Y = 2*pair+1) : B  at X = 2k, G2 at X = 2k+1
// The upper row is emitted as pixels arrive (at most one pixel per 2 clocks).
// {B,G} is parked in a line memory and replayed as a gap-free lower row.
// The output is free running; there is no output backpressure.
//
// Optional build macro RGB2RAW_SOF_EN adds iSOF: an accepted pixel with iSOF=1
// restarts the coordinates at (0,0) and abandons the current frame.
//
// Ports:
//   iCLK, iRST              clock, asynchronous active-low reset
//   iRed/iGreen/iBlue       12-bit input components
//   iDVAL, oREADY           input pixel handshake (accept on iDVAL && oREADY)
//   iSOF                    start-of-frame marker (RGB2RAW_SOF_EN only)
//   oDATA, oDVAL            RAW component and its valid
//   oX_Cont, oY_Cont        RAW column/row of oDATA (held when oDVAL=0)
//   oFRAME_END              pulse with the last component of a frame
module rgb2raw_mosaic #(
    parameter int unsigned IMG_WIDTH  = 1280,
    parameter int unsigned IMG_HEIGHT = 960
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [11:0] iRed,
    input  logic [11:0] iGreen,
    input  logic [11:0] iBlue,
    input  logic        iDVAL,
`ifdef RGB2RAW_SOF_EN
    input  logic        iSOF,
`endif
    output logic        oREADY,
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic [10:0] oX_Cont,
    output logic [10:0] oY_Cont,
    output logic        oFRAME_END
);

    localparam int unsigned LineHalf = IMG_WIDTH / 2;
    localparam int unsigned AddrW    = (LineHalf > 1) ? $clog2(LineHalf) : 1;
    localparam logic [9:0]  LastK    = 10'(LineHalf - 1);
    localparam logic [10:0] LastX    = 11'(IMG_WIDTH - 1);
    localparam logic [9:0]  LastPair = 10'(IMG_HEIGHT / 2 - 1);

    typedef enum logic [1:0] {S_UPPER, S_PREFETCH, S_LOWER} state_t;

    state_t      state;
    logic        armed;
    logic        rPending;
    logic [11:0] redLatch;
    logic [9:0]  pixIdx;
    logic [9:0]  pair;
    logic [10:0] lowerX;
    logic [9:0]  rdAddr;
    logic [9:0]  rdAddrQ;
    logic [23:0] rdData;
    logic [23:0] lineMem [LineHalf];

    logic        accept;
    logic        sof;
    logic [9:0]  kEff;
    logic [9:0]  pairEff;

`ifdef RGB2RAW_SOF_EN
    assign sof = iSOF;
`else
    assign sof = 1'b0;
`endif

    assign oREADY  = armed && (state == S_UPPER) && !rPending;
    assign accept  = iDVAL && oREADY;
    // A start-of-frame pixel is placed at (0,0) regardless of the counters.
    assign kEff    = sof ? 10'd0 : pixIdx;
    assign pairEff = sof ? 10'd0 : pair;

    // Read address is issued one cycle ahead of use: address 0 in the prefetch
    // cycle, then the next entry alongside each G2 so the lower row has no bubbles.
    always_comb begin
        rdAddr = rdAddrQ;
        if (state == S_PREFETCH) begin
            rdAddr = 10'd0;
        end else if (state == S_LOWER && lowerX[0] && lowerX != LastX) begin
            rdAddr = lowerX[10:1] + 10'd1;
        end
    end

    // Line memory {B,G}: plain synchronous RAM, never cleared.
    always_ff @(posedge iCLK) begin
        if (accept) begin
            lineMem[kEff[AddrW-1:0]] <= {iBlue, iGreen};
        end
        rdData <= lineMem[rdAddr[AddrW-1:0]];
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state      <= S_UPPER;
            armed      <= 1'b0;
            rPending   <= 1'b0;
            redLatch   <= '0;
            pixIdx     <= '0;
            pair       <= '0;
            lowerX     <= '0;
            rdAddrQ    <= '0;
            oDATA      <= '0;
            oDVAL      <= 1'b0;
            oX_Cont    <= '0;
            oY_Cont    <= '0;
            oFRAME_END <= 1'b0;
        end else begin
            armed      <= 1'b1;
            oDVAL      <= 1'b0;
            oFRAME_END <= 1'b0;
            rdAddrQ    <= rdAddr;
            case (state)
                S_UPPER: begin
                    if (rPending) begin
                        oDATA    <= redLatch;
                        oDVAL    <= 1'b1;
                        oX_Cont  <= {pixIdx, 1'b1};
                        rPending <= 1'b0;
                        if (pixIdx == LastK) begin
                            pixIdx <= '0;
                            state  <= S_PREFETCH;
                        end else begin
                            pixIdx <= pixIdx + 10'd1;
                        end
                    end else if (accept) begin
                        oDATA    <= iGreen;
                        oDVAL    <= 1'b1;
                        oX_Cont  <= {kEff, 1'b0};
                        oY_Cont  <= {pairEff, 1'b0};
                        pixIdx   <= kEff;
                        pair     <= pairEff;
                        redLatch <= iRed;
                        rPending <= 1'b1;
                    end
                end
                S_PREFETCH: begin
                    lowerX <= '0;
                    state  <= S_LOWER;
                end
                S_LOWER: begin
                    oDVAL   <= 1'b1;
                    oX_Cont <= lowerX;
                    oY_Cont <= {pair, 1'b1};
                    oDATA   <= lowerX[0] ? rdData[11:0] : rdData[23:12];
                    if (lowerX == LastX) begin
                        lowerX <= '0;
                        state  <= S_UPPER;
                        if (pair == LastPair) begin
                            pair       <= '0;
                            oFRAME_END <= 1'b1;
                        end else begin
                            pair <= pair + 10'd1;
                        end
                    end else begin
                        lowerX <= lowerX + 11'd1;
                    end
                end
                default: state <= S_UPPER;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb2raw_mosaic.sv
// Bench for rgb2raw_mosaic at 4x4: directed pixels, expected RAW components
// queued at accept time and popped by an independent output monitor.
module tb_rgb2raw_mosaic;

    localparam int W = 4;
    localparam int H = 4;
`ifdef RGB2RAW_SOF_EN
    localparam bit SofEn = 1'b1;
`else
    localparam bit SofEn = 1'b0;
`endif

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic [11:0] iRed = '0, iGreen = '0, iBlue = '0;
    logic        iDVAL = 1'b0;
    logic        iSOF = 1'b0;
    logic        oREADY, oDVAL, oFRAME_END;
    logic [11:0] oDATA;
    logic [10:0] oX_Cont, oY_Cont;

    rgb2raw_mosaic #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iRed       (iRed),
        .iGreen     (iGreen),
        .iBlue      (iBlue),
        .iDVAL      (iDVAL),
`ifdef RGB2RAW_SOF_EN
        .iSOF       (iSOF),
`endif
        .oREADY     (oREADY),
        .oDATA      (oDATA),
        .oDVAL      (oDVAL),
        .oX_Cont    (oX_Cont),
        .oY_Cont    (oY_Cont),
        .oFRAME_END (oFRAME_END)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [11:0] d;
        logic [10:0] x;
        logic [10:0] y;
        logic        fe;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    int          errors = 0;
    int          checks = 0;
    int          mk = 0;
    int          mpair = 0;
    logic [11:0] lineB [W/2];
    logic [11:0] lineG [W/2];
    bit          prevLower = 1'b0;
    int          waited;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input int d, input int x, input int y, input bit fe);
        exp_t t;
        t.d  = 12'(d);
        t.x  = 11'(x);
        t.y  = 11'(y);
        t.fe = fe;
        sbq.push_back(t);
    endtask

    // Present one pixel, wait (bounded) for acceptance, then queue its components.
    task automatic sendPixel(input logic [11:0] r, input logic [11:0] g, input logic [11:0] b,
                             input bit sof, output int nWait);
        iRed   = r;
        iGreen = g;
        iBlue  = b;
        iSOF   = sof;
        iDVAL  = 1'b1;
        nWait  = 0;
        while (!oREADY && nWait < 100) begin
            @(posedge iCLK);
            #1;
            nWait++;
        end
        if (!oREADY) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: oREADY still 0 after %0d cycles", nWait);
            iDVAL = 1'b0;
            return;
        end
        @(posedge iCLK);
        #1;
        iDVAL = 1'b0;
        iSOF  = 1'b0;
        if (SofEn && sof) begin
            mk    = 0;
            mpair = 0;
        end
        push(g, 2 * mk, 2 * mpair, 1'b0);
        push(r, 2 * mk + 1, 2 * mpair, 1'b0);
        lineB[mk] = b;
        lineG[mk] = g;
        if (mk == W / 2 - 1) begin
            for (int i = 0; i < W / 2; i++) begin
                push(lineB[i], 2 * i, 2 * mpair + 1, 1'b0);
                push(lineG[i], 2 * i + 1, 2 * mpair + 1, (i == W / 2 - 1) && (mpair == H / 2 - 1));
            end
            mk    = 0;
            mpair = (mpair + 1) % (H / 2);
        end else begin
            mk++;
        end
        chk("ready_low_after_accept", oREADY, 0);
    endtask

    // Output monitor.
    always @(negedge iCLK) begin
        if (!iRST) begin
            prevLower = 1'b0;
        end else begin
            if (prevLower) chk("lower_row_contiguous", oDVAL, 1);
            if (oDVAL) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: data 0x%0h at (%0d,%0d), none expected",
                             oDATA, oX_Cont, oY_Cont);
                end else begin
                    e = sbq.pop_front();
                    chk("data", oDATA, e.d);
                    chk("x", oX_Cont, e.x);
                    chk("y", oY_Cont, e.y);
                    chk("frame_end", oFRAME_END, e.fe);
                end
            end else begin
                chk("frame_end_idle", oFRAME_END, 0);
            end
            prevLower = oDVAL && oY_Cont[0] && (oX_Cont != 11'(W - 1));
        end
    end

    initial begin
        // Reset with iDVAL held high and pixel A presented.
        iRed = 12'h100; iGreen = 12'h200; iBlue = 12'h300; iDVAL = 1'b1;
        repeat (3) @(posedge iCLK);
        #1;
        chk("rst_oDATA", oDATA, 0);
        chk("rst_oDVAL", oDVAL, 0);
        chk("rst_oX", oX_Cont, 0);
        chk("rst_oY", oY_Cont, 0);
        chk("rst_frame_end", oFRAME_END, 0);
        chk("rst_ready", oREADY, 0);
        iRST = 1'b1;
        #1;
        chk("ready_before_arm", oREADY, 0);
        @(posedge iCLK);
        #1;
        chk("ready_after_arm", oREADY, 1);

        // Row pair 0, then pair 1 which ends the frame.
        sendPixel(12'h100, 12'h200, 12'h300, 1'b0, waited);
        chk("wait_A", waited, 0);
        sendPixel(12'h101, 12'h201, 12'h301, 1'b0, waited);
        chk("wait_B", waited, 1);
        sendPixel(12'h110, 12'h210, 12'h310, 1'b0, waited);
        chk("wait_after_lower_row", waited, 6);
        sendPixel(12'h111, 12'h211, 12'h311, 1'b0, waited);
        // New frame starts at (0,0); then gapped input.
        sendPixel(12'h120, 12'h220, 12'h320, 1'b0, waited);
        for (int i = 1; i < 4; i++) begin
            repeat (4) @(posedge iCLK);
            #1;
            sendPixel(12'(12'h120 + i), 12'(12'h220 + i), 12'(12'h320 + i), 1'b0, waited);
        end

        // Reset mid-line: the partial line is discarded.
        sendPixel(12'h130, 12'h230, 12'h330, 1'b0, waited);
        repeat (2) @(posedge iCLK);
        #1;
        chk("queue_empty_before_reset", sbq.size(), 0);
        iRST = 1'b0;
        #1;
        chk("midrst_oDVAL", oDVAL, 0);
        chk("midrst_ready", oREADY, 0);
        mk = 0;
        mpair = 0;
        @(posedge iCLK);
        #1;
        iRST = 1'b1;
        sendPixel(12'h140, 12'h240, 12'h340, 1'b0, waited);
        sendPixel(12'h141, 12'h241, 12'h341, 1'b0, waited);
        sendPixel(12'h142, 12'h242, 12'h342, 1'b0, waited);
        sendPixel(12'h143, 12'h243, 12'h343, 1'b0, waited);

`ifdef RGB2RAW_SOF_EN
        // iSOF on the second pixel of line Y=2 restarts at (0,0).
        sendPixel(12'h150, 12'h250, 12'h350, 1'b0, waited);
        sendPixel(12'h151, 12'h251, 12'h351, 1'b0, waited);
        sendPixel(12'h152, 12'h252, 12'h352, 1'b0, waited);
        sendPixel(12'h153, 12'h253, 12'h353, 1'b1, waited);
        sendPixel(12'h154, 12'h254, 12'h354, 1'b0, waited);
        sendPixel(12'h155, 12'h255, 12'h355, 1'b0, waited);
        sendPixel(12'h156, 12'h256, 12'h356, 1'b0, waited);
`endif

        for (int i = 0; i < 50 && sbq.size() > 0; i++) @(posedge iCLK);
        repeat (2) @(posedge iCLK);
        #1;
        chk("queue_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
